// File: rtl/peripheral_noc_packet_arbiter.sv
// rtl/peripheral_noc_packet_arbiter.sv - packet-granular round-robin arbiter onto one registered NoC link
// A grant is held from a packet's first flit through its last flit; one bubble per packet for arbitration.
module peripheral_noc_packet_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int CW         = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS-1:0]            grant
);

  if (CHANNELS < 2) begin : g_bad_channels
    $fatal(1, "peripheral_noc_packet_arbiter: CHANNELS must be at least 2");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_ptr;
  logic [CW-1:0]         w_ptr_nxt;
  logic [CW-1:0]         r_gidx;
  logic [CW-1:0]         w_gidx_nxt;
  logic [CHANNELS-1:0]   r_grant;
  logic [CHANNELS-1:0]   w_grant_nxt;
  logic [CW-1:0]         w_win;
  logic [CW:0]           w_cand;
  logic [CHANNELS-1:0]   w_win_onehot;
  logic                  w_any_req;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_xfer_last;
  logic [FLIT_WIDTH-1:0] w_xfer_flit;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [FLIT_WIDTH-1:0] r_out_flit;

  // Scan from the lowest priority upward so the last hit is the first requester after r_ptr.
  always_comb begin
    w_win  = r_ptr;
    w_cand = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_cand >= (CW+1)'(CHANNELS)) begin
        w_cand = w_cand - (CW+1)'(CHANNELS);
      end
      if (in_valid[w_cand[CW-1:0]]) begin
        w_win = w_cand[CW-1:0];
      end
    end
  end

  assign w_any_req    = |in_valid;
  assign w_win_onehot = CHANNELS'(1) << w_win;
  assign w_out_free   = ~r_out_valid | out_ready;
  assign w_xfer_flit  = in_flit[r_gidx*FLIT_WIDTH +: FLIT_WIDTH];
  assign w_xfer_last  = in_last[r_gidx];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    in_ready    = '0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_LOCKED;
          w_gidx_nxt  = w_win;
          w_grant_nxt = w_win_onehot;
        end
      end
      ST_LOCKED: begin
        // The owner keeps the link even while its in_valid is low; no timeout.
        in_ready[r_gidx] = w_out_free;
        w_xfer           = in_valid[r_gidx] & w_out_free;
        if (w_xfer && w_xfer_last) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_gidx == CW'(CHANNELS - 1)) ? '0 : r_gidx + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // A load wins over a drain, so a simultaneous load and drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_flit  <= w_xfer_flit;
      r_out_last  <= w_xfer_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign out_last  = r_out_last;
  assign grant     = r_grant;

endmodule

// File: doc/peripheral_noc_packet_arbiter.md
# peripheral_noc_packet_arbiter

Packet-granular round-robin arbiter that shares one NoC output link among CHANNELS upstream flit buffers. A grant is held for a whole packet, from the first flit through the flit with `last` set. Flits leave through a single registered output stage. The block sits between a bank of per-source `peripheral_noc_buffer` FIFOs and a link or router input port, and it sequences which buffer drains onto that link.

## Interface
- `FLIT_WIDTH`, default 32: flit payload width in bits.
- `CHANNELS`, default 4: number of requesting input channels. Must be ≥ 2; an elaboration-time `$fatal` fires otherwise. Need not be a power of two.
- `CW`, default `$clog2(CHANNELS)`: width of the round-robin pointer. Derived; do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_flit`  in  CHANNELS*FLIT_WIDTH  channel i occupies bits `[i*FLIT_WIDTH +: FLIT_WIDTH]`.
- `in_last`  in  CHANNELS  bit i marks the final flit of channel i's packet.
- `in_valid`  in  CHANNELS  bit i means channel i presents a flit.
- `in_ready`  out  CHANNELS  bit i means channel i's flit is accepted this cycle.
- `out_flit`  out  FLIT_WIDTH  registered output flit.
- `out_last`  out  1  registered last marker.
- `out_valid`  out  1  output register holds a flit.
- `out_ready`  in  1  downstream accepts the flit.
- `grant`  out  CHANNELS  one-hot channel currently holding the link; all-zero when idle.

## Operation
- Two states:
  - IDLE: no grant.
  - LOCKED: one channel owns the link.
- Round-robin pointer `ptr` (CW bits) names the highest-priority channel. Search order is `ptr, ptr+1, …`, wrapping modulo CHANNELS.
- In IDLE with any `in_valid` set:
  - Select the first requesting channel in search order.
  - Register `grant` to that one-hot value and move to LOCKED at the next edge.
  - All `in_ready` are 0 in IDLE. No flit transfers during the arbitration cycle.
- In LOCKED on channel g:
  - `in_ready[g] = ~out_valid | out_ready`. Every other `in_ready` bit is 0.
  - A transfer occurs when `in_valid[g] & in_ready[g]`.
  - On each transfer, load `{in_last[g], in_flit[g]}` into the output register and set `out_valid`.
- A transfer with `in_last[g]=1` ends the packet:
  - Next state is IDLE.
  - `grant` becomes 0.
  - `ptr` becomes `(g+1) mod CHANNELS`.
- If `in_valid[g]` drops mid-packet, stay LOCKED on g. No other channel is served until g delivers its last flit. The grant has no timeout.
- Output register:
  - Cleared when `out_valid & out_ready` and no load occurs.
  - Holds its value while `out_valid & ~out_ready`.
  - A load and a drain in the same cycle replace the contents, so `out_valid` stays 1.
- A single-flit packet (first flit carries `in_last`) returns to IDLE after one transfer.
- Upstream obeys the NoC valid rule: once `in_valid[i]` is raised it holds until accepted. The arbiter does not re-check a winner's `in_valid` after granting.

## Timing
- Reset asserted, asynchronously:
  - State = IDLE, `ptr` = 0, `grant` = 0.
  - `out_valid` = 0, `out_flit` = 0, `out_last` = 0.
  - `in_ready` = 0.
- Reset mid-packet discards the partial packet. Upstream buffers are reset with the arbiter.
- Release is synchronous to `clk`; the first arbitration can occur on the first edge after release.
- Arbitration latency: request visible at edge k produces `grant` after edge k and `in_ready` during cycle k+1.
- Input-to-output latency: a flit accepted at edge n appears on `out_flit`/`out_valid` after edge n (1 cycle).
- Throughput:
  - With `out_ready` held at 1, one flit per cycle within a packet.
  - An L-flit packet occupies L+1 arbiter cycles: one bubble per packet for arbitration.
- `in_ready` is a combinational function of registered `grant`, `out_valid` and input `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Back-to-back packets from the same channel are permitted only if no other channel requests during that channel's IDLE arbitration cycle.

## Test plan
- Reset then idle: `rst=0` for 3 cycles, release with all `in_valid=0` → `grant=0`, `out_valid=0`, `in_ready=0` held for 10 cycles.
- Single-channel packet: channel 2 sends 3 flits 0xA0, 0xA1, 0xA2 (last), `out_ready=1` → `grant=4'b0100` after 1 cycle; `out_flit` shows 0xA0, 0xA1, 0xA2 on consecutive cycles with `out_last=1` on 0xA2; `grant=0` and `ptr=3` afterwards.
- Round-robin fairness: all 4 channels continuously send 2-flit packets → grant order 0, 1, 2, 3, 0, …; each packet takes 3 cycles; no channel is served twice before the others are served once.
- Packet lock under contention: channel 1 stalls `in_valid` for 5 cycles mid-packet while channel 0 requests → `grant` stays `4'b0010`, `in_ready[0]=0` throughout; channel 0 is served only after channel 1's last flit.
- Backpressure: `out_ready=0` for 4 cycles during a packet → `out_flit` stable, `in_ready[g]=0`, no flit lost or duplicated; on release, transfer resumes in order.
- Asynchronous reset mid-packet: assert `rst` between edges during flit 2 of 4 → outputs clear immediately without a clock edge; after release, a new request from channel 3 is granted from `ptr=0` search order.
